// File: rtl/noc_test_sink.sv
// Receive-side NoC traffic checker: parses ejected flits into packets, checks dest/framing/length/payload, keeps stats.
// Latency: outputs registered one cycle after the accepting edge; flit_ready is combinational (~sink_stall, low in reset).
module noc_test_sink #(
    parameter logic [2:0] X_ID  = 3'd0,
    parameter logic [2:0] Y_ID  = 3'd0,
    parameter int         CNT_W = 16
) (
    input  logic             noc_clk,
    input  logic             noc_rst,
    input  logic             flit_valid,
    output logic             flit_ready,
    input  logic [31:0]      flit_data,
    input  logic             sink_stall,
    input  logic             clr_stats,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] flit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       err_flags,
    output logic [5:0]       last_src
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    state_t           state_q, state_d;
    logic [9:0]       cur_seq_q, cur_seq_d;
    logic [7:0]       cur_len_q, cur_len_d;
    logic [19:0]      cur_idx_q, cur_idx_d;
    logic [5:0]       cur_src_q, cur_src_d;
    logic [CNT_W-1:0] pkt_cnt_q, flit_cnt_q, err_cnt_q;
    logic [3:0]       err_flags_q;
    logic [5:0]       last_src_q, last_src_d;
    logic             pkt_done_q;

    logic       xfer;
    logic [1:0] ftype;
    logic       is_head, is_single, is_body, is_tail;
    logic       complete;
    logic       e_dst, e_frm, e_len, e_pay;
    logic [3:0] flit_err;

    assign flit_ready = ~sink_stall & ~noc_rst;
    assign xfer       = flit_valid & flit_ready;
    assign ftype      = flit_data[31:30];
    assign is_head    = (ftype == T_HEAD);
    assign is_single  = (ftype == T_SINGLE);
    assign is_body    = (ftype == T_BODY);
    assign is_tail    = (ftype == T_TAIL);
    assign flit_err   = {e_pay, e_len, e_frm, e_dst};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d    = state_q;
        cur_seq_d  = cur_seq_q;
        cur_len_d  = cur_len_q;
        cur_idx_d  = cur_idx_q;
        cur_src_d  = cur_src_q;
        last_src_d = last_src_q;
        complete   = 1'b0;
        e_dst      = 1'b0;
        e_frm      = 1'b0;
        e_len      = 1'b0;
        e_pay      = 1'b0;
        if (xfer) begin
            if (is_head || is_single) begin
                // A head mid-packet abandons the old packet and resynchronises on the new one.
                e_frm = (state_q == S_BODY);
                e_dst = (flit_data[29:24] != {X_ID, Y_ID});
                if (is_single) begin
                    complete   = 1'b1;
                    last_src_d = flit_data[23:18];
                    e_len      = (flit_data[17:10] != 8'd0);
                    state_d    = S_IDLE;
                end else if (flit_data[17:10] != 8'd0) begin
                    cur_seq_d = flit_data[9:0];
                    cur_len_d = flit_data[17:10];
                    cur_idx_d = 20'd1;
                    cur_src_d = flit_data[23:18];
                    state_d   = S_BODY;
                end else begin
                    // A head announcing no following flits can never be closed: flag and drop it.
                    e_len   = 1'b1;
                    state_d = S_IDLE;
                end
            end else if (state_q == S_IDLE) begin
                e_frm = 1'b1;
            end else begin
                e_pay = (flit_data[29:20] != cur_seq_q) || (flit_data[19:0] != cur_idx_q);
                if (is_tail) begin
                    e_len      = (cur_idx_q != {12'd0, cur_len_q});
                    complete   = 1'b1;
                    last_src_d = cur_src_q;
                    state_d    = S_IDLE;
                end else if (is_body) begin
                    e_len     = (cur_idx_q == {12'd0, cur_len_q});
                    cur_idx_d = cur_idx_q + 20'd1;
                end
            end
        end
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_q     <= S_IDLE;
            cur_seq_q   <= '0;
            cur_len_q   <= '0;
            cur_idx_q   <= '0;
            cur_src_q   <= '0;
            pkt_cnt_q   <= '0;
            flit_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_flags_q <= '0;
            last_src_q  <= '0;
            pkt_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_seq_q  <= cur_seq_d;
            cur_len_q  <= cur_len_d;
            cur_idx_q  <= cur_idx_d;
            cur_src_q  <= cur_src_d;
            last_src_q <= last_src_d;
            pkt_done_q <= complete;
            // Clear takes priority over any same-cycle transfer statistics.
            if (clr_stats) begin
                pkt_cnt_q   <= '0;
                flit_cnt_q  <= '0;
                err_cnt_q   <= '0;
                err_flags_q <= '0;
            end else begin
                if (xfer) begin
                    flit_cnt_q <= sat_inc(flit_cnt_q);
                end
                if (complete) begin
                    pkt_cnt_q <= sat_inc(pkt_cnt_q);
                end
                if (|flit_err) begin
                    err_cnt_q   <= sat_inc(err_cnt_q);
                    err_flags_q <= err_flags_q | flit_err;
                end
            end
        end
    end

    assign pkt_done  = pkt_done_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign flit_cnt  = flit_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_flags = err_flags_q;
    assign last_src  = last_src_q;

endmodule

// File: tb/tb_noc_test_sink.sv
// Bench for noc_test_sink at node (2,1) with narrow counters so saturation is reachable.
module tb_noc_test_sink;

    localparam int CW = 4;

    logic          noc_clk = 1'b0;
    logic          noc_rst;
    logic          flit_valid;
    logic          flit_ready;
    logic [31:0]   flit_data;
    logic          sink_stall;
    logic          clr_stats;
    logic          pkt_done;
    logic [CW-1:0] pkt_cnt, flit_cnt, err_cnt;
    logic [3:0]    err_flags;
    logic [5:0]    last_src;

    always #5 noc_clk = ~noc_clk;

    noc_test_sink #(.X_ID(3'd2), .Y_ID(3'd1), .CNT_W(CW)) dut (
        .noc_clk    (noc_clk),
        .noc_rst    (noc_rst),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_data  (flit_data),
        .sink_stall (sink_stall),
        .clr_stats  (clr_stats),
        .pkt_done   (pkt_done),
        .pkt_cnt    (pkt_cnt),
        .flit_cnt   (flit_cnt),
        .err_cnt    (err_cnt),
        .err_flags  (err_flags),
        .last_src   (last_src)
    );

    typedef struct {
        logic        valid;
        logic        stall;
        logic        clr;
        logic [31:0] data;
        logic        done;
        int          pkt;
        int          flit;
        int          err;
        logic [3:0]  flags;
        logic [5:0]  src;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] f_head(input logic [2:0] dx, input logic [2:0] dy, input logic [2:0] sx,
                                           input logic [2:0] sy, input logic [7:0] len, input logic [9:0] seq);
        return {2'b01, dx, dy, sx, sy, len, seq};
    endfunction

    function automatic logic [31:0] f_single(input logic [2:0] dx, input logic [2:0] dy, input logic [2:0] sx,
                                             input logic [2:0] sy, input logic [7:0] len, input logic [9:0] seq);
        return {2'b11, dx, dy, sx, sy, len, seq};
    endfunction

    function automatic logic [31:0] f_body(input logic [9:0] seq, input logic [19:0] idx);
        return {2'b00, seq, idx};
    endfunction

    function automatic logic [31:0] f_tail(input logic [9:0] seq, input logic [19:0] idx);
        return {2'b10, seq, idx};
    endfunction

    function automatic vec_t mk(input logic v, input logic s, input logic c, input logic [31:0] d, input logic dn,
                                input int p, input int f, input int e, input logic [3:0] fl, input logic [5:0] sr);
        vec_t r;
        r.valid = v; r.stall = s; r.clr = c; r.data = d; r.done = dn;
        r.pkt = p; r.flit = f; r.err = e; r.flags = fl; r.src = sr;
        return r;
    endfunction

    function automatic int sat(input int i);
        return (i > 15) ? 15 : i;
    endfunction

    task automatic check_out(input string tag, input vec_t e);
        chk({tag, "_done"},  32'(pkt_done),  32'(e.done));
        chk({tag, "_pkt"},   32'(pkt_cnt),   32'(e.pkt));
        chk({tag, "_flit"},  32'(flit_cnt),  32'(e.flit));
        chk({tag, "_err"},   32'(err_cnt),   32'(e.err));
        chk({tag, "_flags"}, 32'(err_flags), 32'(e.flags));
        chk({tag, "_src"},   32'(last_src),  32'(e.src));
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input string tag, input vec_t v);
        @(negedge noc_clk);
        flit_valid = v.valid;
        sink_stall = v.stall;
        clr_stats  = v.clr;
        flit_data  = v.data;
        exp_q.push_back(v);
        #1 chk({tag, "_ready"}, 32'(flit_ready), 32'(!v.stall));
        @(posedge noc_clk);
        #1 check_out(tag, exp_q.pop_front());
    endtask

    logic [31:0] sflits[10];

    initial begin
        int ptr, dones, cyc;
        vec_t rst_v;
        noc_rst = 1'b1; flit_valid = 1'b0; sink_stall = 1'b0; clr_stats = 1'b0; flit_data = '0;
        rst_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 6'b000000);

        // Reset state
        #1 chk("rst_ready", 32'(flit_ready), 32'd0);
        repeat (2) @(posedge noc_clk);
        #1 check_out("rst", rst_v);
        @(negedge noc_clk);
        noc_rst = 1'b0;

        // Basic packet, then single dest error, then length/framing, payload/resync, clear coincident with transfers
        tbl.push_back(mk(1, 0, 0, f_head(2, 1, 5, 3, 3, 7), 0, 0, 1, 0, 4'b0000, 6'b000000));
        tbl.push_back(mk(1, 0, 0, f_body(7, 1),             0, 0, 2, 0, 4'b0000, 6'b000000));
        tbl.push_back(mk(1, 1, 0, f_body(7, 2),             0, 0, 2, 0, 4'b0000, 6'b000000));
        tbl.push_back(mk(1, 0, 0, f_body(7, 2),             0, 0, 3, 0, 4'b0000, 6'b000000));
        tbl.push_back(mk(1, 0, 0, f_tail(7, 3),             1, 1, 4, 0, 4'b0000, 6'b101011));
        tbl.push_back(mk(0, 0, 0, 32'd0,                    0, 1, 4, 0, 4'b0000, 6'b101011));
        tbl.push_back(mk(0, 0, 1, 32'd0,                    0, 0, 0, 0, 4'b0000, 6'b101011));
        tbl.push_back(mk(1, 0, 0, f_single(3, 1, 1, 2, 0, 9), 1, 1, 1, 1, 4'b0001, 6'b001010));
        tbl.push_back(mk(0, 0, 1, 32'd0,                    0, 0, 0, 0, 4'b0000, 6'b001010));
        tbl.push_back(mk(1, 0, 0, f_head(2, 1, 4, 4, 2, 3), 0, 0, 1, 0, 4'b0000, 6'b001010));
        tbl.push_back(mk(1, 0, 0, f_tail(3, 1),             1, 1, 2, 1, 4'b0100, 6'b100100));
        tbl.push_back(mk(1, 0, 0, f_body(3, 1),             0, 1, 3, 2, 4'b0110, 6'b100100));
        tbl.push_back(mk(0, 0, 1, 32'd0,                    0, 0, 0, 0, 4'b0000, 6'b100100));
        tbl.push_back(mk(1, 0, 0, f_head(2, 1, 1, 1, 2, 5), 0, 0, 1, 0, 4'b0000, 6'b100100));
        tbl.push_back(mk(1, 0, 0, f_body(6, 1),             0, 0, 2, 1, 4'b1000, 6'b100100));
        tbl.push_back(mk(1, 0, 0, f_head(2, 1, 3, 2, 1, 8), 0, 0, 3, 2, 4'b1010, 6'b100100));
        tbl.push_back(mk(1, 0, 0, f_tail(8, 1),             1, 1, 4, 2, 4'b1010, 6'b011010));
        tbl.push_back(mk(0, 0, 1, 32'd0,                    0, 0, 0, 0, 4'b0000, 6'b011010));
        tbl.push_back(mk(1, 0, 0, f_head(2, 1, 7, 0, 1, 1), 0, 0, 1, 0, 4'b0000, 6'b011010));
        tbl.push_back(mk(1, 0, 1, f_tail(1, 1),             1, 0, 0, 0, 4'b0000, 6'b111000));
        tbl.push_back(mk(1, 0, 1, f_head(0, 0, 2, 2, 1, 2), 0, 0, 0, 0, 4'b0000, 6'b111000));
        tbl.push_back(mk(1, 0, 0, f_tail(2, 1),             1, 1, 1, 0, 4'b0000, 6'b010010));
        tbl.push_back(mk(1, 0, 0, f_single(2, 1, 1, 1, 3, 0), 1, 2, 2, 1, 4'b0100, 6'b001001));
        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Valid held high while the stall toggles every cycle across two len-4 packets
        apply("stclr", mk(0, 0, 1, 32'd0, 0, 0, 0, 0, 4'b0000, 6'b001001));
        for (int p = 0; p < 2; p++) begin
            sflits[p*5] = f_head(2, 1, 4, 2, 4, 10'(11 + p));
            for (int b = 1; b <= 3; b++) sflits[p*5+b] = f_body(10'(11 + p), 20'(b));
            sflits[p*5+4] = f_tail(10'(11 + p), 20'd4);
        end
        ptr = 0; dones = 0; cyc = 0;
        while (ptr < 10 && cyc < 100) begin
            @(negedge noc_clk);
            flit_valid = 1'b1;
            clr_stats  = 1'b0;
            sink_stall = cyc[0];
            flit_data  = sflits[ptr];
            #1 chk("st_ready", 32'(flit_ready), 32'(!cyc[0]));
            @(posedge noc_clk);
            #1;
            if (!sink_stall) ptr++;
            chk("st_flit", 32'(flit_cnt), 32'(ptr));
            dones += int'(pkt_done);
            cyc++;
        end
        @(negedge noc_clk);
        flit_valid = 1'b0; sink_stall = 1'b0;
        @(posedge noc_clk);
        #1;
        chk("st_ptr", 32'(ptr), 32'd10);
        chk("st_dones", 32'(dones), 32'd2);
        check_out("st_end", mk(0, 0, 0, 0, 0, 2, 10, 0, 4'b0000, 6'b100010));

        // Saturation of all three counters at all-ones
        apply("satclr", mk(0, 0, 1, 32'd0, 0, 0, 0, 0, 4'b0000, 6'b100010));
        for (int i = 1; i <= 18; i++) begin
            apply($sformatf("sat%0d", i),
                  mk(1, 0, 0, f_single(3, 1, 1, 2, 0, 10'(i)), 1, sat(i), sat(i), sat(i), 4'b0001, 6'b001010));
        end

        // Reset asserted mid-packet, then a fresh packet must be accepted cleanly
        apply("rmclr", mk(0, 0, 1, 32'd0, 0, 0, 0, 0, 4'b0000, 6'b001010));
        apply("rm_h",  mk(1, 0, 0, f_head(2, 1, 5, 5, 3, 20), 0, 0, 1, 0, 4'b0000, 6'b001010));
        apply("rm_b",  mk(1, 0, 0, f_body(20, 1),             0, 0, 2, 0, 4'b0000, 6'b001010));
        @(negedge noc_clk);
        flit_valid = 1'b0;
        #2 noc_rst = 1'b1;
        #1;
        chk("rm_ready", 32'(flit_ready), 32'd0);
        check_out("rm_rst", rst_v);
        @(negedge noc_clk);
        noc_rst = 1'b0;
        apply("rm_h2", mk(1, 0, 0, f_head(2, 1, 6, 5, 1, 4), 0, 0, 1, 0, 4'b0000, 6'b000000));
        apply("rm_t2", mk(1, 0, 0, f_tail(4, 1),             1, 1, 2, 0, 4'b0000, 6'b110101));
        apply("rm_idle", mk(0, 0, 0, 32'd0,                  0, 1, 2, 0, 4'b0000, 6'b110101));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
